// File: rtl/game_pkg.sv
// Shared types for the 1A2B game: entry FSM states and BCD digits.
// Also used by the scorer and display blocks.
package game_pkg;

    typedef enum logic [2:0] {
        IDLE,
        EDIT,
        CHECK,
        SEND,
        DONE
    } state_t;

    localparam int NUM_DIGITS = 4;
    localparam int DIGIT_MAX  = 9;

    typedef logic [3:0] digit_t;

    // BCD increment, 9 wraps to 0
    function automatic digit_t digit_inc(digit_t d);
        return (d == digit_t'(DIGIT_MAX)) ? digit_t'(0) : digit_t'(d + 4'd1);
    endfunction

endpackage

// File: rtl/btn_edge.sv
// Button synchronizer followed by a rising-edge detector.
// Each press gives exactly one single-cycle pulse.
module btn_edge #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic btn,
    output logic pulse
);

    logic [SYNC_STAGES-1:0] sync;
    logic                   last;

    // shift raw button through the sync chain, remember previous synced level
    always_ff @(posedge clk) begin
        if (rst) begin
            sync <= '0;
            last <= 1'b0;
        end else begin
            sync <= {sync[SYNC_STAGES-2:0], btn};
            last <= sync[SYNC_STAGES-1];
        end
    end

    assign pulse = sync[SYNC_STAGES-1] & ~last;

endmodule

// File: rtl/guess_entry_ctrl.sv
// Guess-entry sequencer: button edits, duplicate rejection,
// valid/ready hand-off to the scorer and per-game attempt count.
module guess_entry_ctrl
    import game_pkg::*;
#(
    parameter int MAX_TRIES   = 10,
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       new_game,
    input  logic       game_over,
    input  logic       btn_inc,
    input  logic       btn_next,
    input  logic       btn_ok,
    output logic [3:0] d0,
    output logic [3:0] d1,
    output logic [3:0] d2,
    output logic [3:0] d3,
    output logic [1:0] cur,
    output logic       guess_valid,
    input  logic       guess_ready,
    output logic       dup_err,
    output logic [3:0] tries,
    output logic       busy
);

    localparam logic [3:0] TRIES_MAX = 4'(MAX_TRIES);

    state_t state;
    digit_t dig [NUM_DIGITS];
    logic   ev_inc;
    logic   ev_next;
    logic   ev_ok;
    logic   dup;
    logic [3:0] tries_nxt;

    btn_edge #(.SYNC_STAGES(SYNC_STAGES)) u_inc (
        .clk   (clk),
        .rst   (rst),
        .btn   (btn_inc),
        .pulse (ev_inc)
    );

    btn_edge #(.SYNC_STAGES(SYNC_STAGES)) u_next (
        .clk   (clk),
        .rst   (rst),
        .btn   (btn_next),
        .pulse (ev_next)
    );

    btn_edge #(.SYNC_STAGES(SYNC_STAGES)) u_ok (
        .clk   (clk),
        .rst   (rst),
        .btn   (btn_ok),
        .pulse (ev_ok)
    );

    // any of the six digit pairs equal means the guess is illegal
    always_comb begin
        dup = (dig[0] == dig[1]) | (dig[0] == dig[2]) |
              (dig[0] == dig[3]) | (dig[1] == dig[2]) |
              (dig[1] == dig[3]) | (dig[2] == dig[3]);
    end

    assign tries_nxt = tries + 4'd1;

    // entry FSM with registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            for (int i = 0; i < NUM_DIGITS; i++) dig[i] <= '0;
            cur         <= '0;
            guess_valid <= 1'b0;
            dup_err     <= 1'b0;
            tries       <= '0;
            busy        <= 1'b0;
        end else if (new_game) begin
            state       <= EDIT;
            for (int i = 0; i < NUM_DIGITS; i++) dig[i] <= '0;
            cur         <= '0;
            guess_valid <= 1'b0;
            dup_err     <= 1'b0;
            tries       <= '0;
            busy        <= 1'b1;
        end else begin
            dup_err <= 1'b0;
            unique case (state)
                IDLE: ;
                EDIT: begin
                    if (game_over) begin
                        state <= DONE;
                        busy  <= 1'b0;
                    end else if (ev_ok) begin
                        state <= CHECK;
                    end else if (ev_next) begin
                        cur <= cur + 2'd1;
                    end else if (ev_inc) begin
                        dig[cur] <= digit_inc(dig[cur]);
                    end
                end
                CHECK: begin
                    if (dup) begin
                        dup_err <= 1'b1;
                        cur     <= '0;
                        state   <= EDIT;
                    end else begin
                        guess_valid <= 1'b1;
                        state       <= SEND;
                    end
                end
                SEND: begin
                    if (guess_ready) begin
                        guess_valid <= 1'b0;
                        tries       <= tries_nxt;
                        cur         <= '0;
                        if (tries_nxt == TRIES_MAX) begin
                            state <= DONE;
                            busy  <= 1'b0;
                        end else begin
                            state <= EDIT;
                        end
                    end
                end
                DONE: ;
                default: state <= IDLE;
            endcase
        end
    end

    assign d0 = dig[0];
    assign d1 = dig[1];
    assign d2 = dig[2];
    assign d3 = dig[3];

endmodule

// File: tb/tb_guess_entry_ctrl.sv
// Testbench for guess_entry_ctrl: directed game scenarios plus random
// button traffic, compared every cycle against a behavioural model.
module tb_guess_entry_ctrl;

    localparam int MAXT = 2;
    localparam int SYNC = 2;

    localparam int M_IDLE  = 0;
    localparam int M_EDIT  = 1;
    localparam int M_CHECK = 2;
    localparam int M_SEND  = 3;
    localparam int M_DONE  = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       new_game = 1'b0;
    logic       game_over = 1'b0;
    logic       btn_inc = 1'b0;
    logic       btn_next = 1'b0;
    logic       btn_ok = 1'b0;
    logic       guess_ready = 1'b0;
    logic [3:0] d0, d1, d2, d3;
    logic [1:0] cur;
    logic       guess_valid;
    logic       dup_err;
    logic [3:0] tries;
    logic       busy;

    int n_tests = 0;
    int n_fail  = 0;

    // reference model state
    int         md [4];
    int         mcur = 0;
    int         mtries = 0;
    int         mode = M_IDLE;
    int         mdup = 0;
    logic [2:0] prev = 3'b000;
    logic [2:0] evq [$];

    guess_entry_ctrl #(
        .MAX_TRIES   (MAXT),
        .SYNC_STAGES (SYNC)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .new_game    (new_game),
        .game_over   (game_over),
        .btn_inc     (btn_inc),
        .btn_next    (btn_next),
        .btn_ok      (btn_ok),
        .d0          (d0),
        .d1          (d1),
        .d2          (d2),
        .d3          (d3),
        .cur         (cur),
        .guess_valid (guess_valid),
        .guess_ready (guess_ready),
        .dup_err     (dup_err),
        .tries       (tries),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int obs, input int exp);
        n_tests++;
        if (obs != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic bit model_has_dup();
        for (int i = 0; i < 4; i++)
            for (int j = i + 1; j < 4; j++)
                if (md[i] == md[j]) return 1'b1;
        return 1'b0;
    endfunction

    task automatic model_clear();
        for (int i = 0; i < 4; i++) md[i] = 0;
        mcur   = 0;
        mtries = 0;
    endtask

    // one clock edge of the specified behaviour, using the inputs seen at it
    task automatic model_step();
        logic [2:0] raw;
        logic [2:0] act;
        raw  = {btn_ok, btn_next, btn_inc};
        mdup = 0;
        if (rst) begin
            model_clear();
            mode = M_IDLE;
            prev = 3'b000;
            evq.delete();
            for (int i = 0; i < SYNC; i++) evq.push_back(3'b000);
            return;
        end
        // a rise seen now acts SYNC edges later
        act = evq.pop_front();
        evq.push_back(raw & ~prev);
        prev = raw;
        if (new_game) begin
            model_clear();
            mode = M_EDIT;
            return;
        end
        case (mode)
            M_EDIT: begin
                if (game_over) mode = M_DONE;
                else if (act[2]) mode = M_CHECK;
                else if (act[1]) mcur = (mcur + 1) % 4;
                else if (act[0]) md[mcur] = (md[mcur] + 1) % 10;
            end
            M_CHECK: begin
                if (model_has_dup()) begin
                    mdup = 1;
                    mcur = 0;
                    mode = M_EDIT;
                end else begin
                    mode = M_SEND;
                end
            end
            M_SEND: begin
                if (guess_ready) begin
                    mtries++;
                    mcur = 0;
                    mode = (mtries == MAXT) ? M_DONE : M_EDIT;
                end
            end
            default: ;
        endcase
    endtask

    task automatic check_outputs();
        check("d0", int'(d0), md[0]);
        check("d1", int'(d1), md[1]);
        check("d2", int'(d2), md[2]);
        check("d3", int'(d3), md[3]);
        check("cur", int'(cur), mcur);
        check("tries", int'(tries), mtries);
        check("guess_valid", int'(guess_valid), int'(mode == M_SEND));
        check("dup_err", int'(dup_err), mdup);
        check("busy", int'(busy),
              int'(mode == M_EDIT || mode == M_CHECK || mode == M_SEND));
    endtask

    // inputs are set before this; outputs compared on the falling edge
    task automatic cycle();
        @(posedge clk);
        model_step();
        @(negedge clk);
        check_outputs();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    // which: 0 inc, 1 next, 2 ok
    task automatic press(input int which);
        btn_inc  = (which == 0);
        btn_next = (which == 1);
        btn_ok   = (which == 2);
        cycle();
        btn_inc  = 1'b0;
        btn_next = 1'b0;
        btn_ok   = 1'b0;
        cycle();
    endtask

    task automatic press_n(input int which, input int n);
        for (int i = 0; i < n; i++) press(which);
    endtask

    initial begin
        for (int i = 0; i < 4; i++) md[i] = 0;

        // reset then first game
        idle(2);
        rst = 1'b0;
        idle(2);
        new_game = 1'b1;
        cycle();
        new_game = 1'b0;
        press_n(0, 11);
        idle(3);

        // build 1,2,3,4 and send with the scorer stalled
        press(1); press_n(0, 2);
        press(1); press_n(0, 3);
        press(1); press_n(0, 4);
        press(1);
        idle(2);
        press(2);
        idle(2);
        press(0); press(1);
        btn_inc = 1'b1;
        idle(4);
        btn_inc = 1'b0;
        guess_ready = 1'b1;
        idle(2);
        guess_ready = 1'b0;
        idle(3);

        // 1,1,3,4 is rejected
        press(1); press_n(0, 9);
        idle(2);
        press(2);
        idle(5);

        // inc and next together: next wins
        btn_inc  = 1'b1;
        btn_next = 1'b1;
        cycle();
        btn_inc  = 1'b0;
        btn_next = 1'b0;
        idle(3);

        // second accepted guess reaches the try limit
        press(0);
        idle(2);
        guess_ready = 1'b1;
        press(2);
        idle(4);
        guess_ready = 1'b0;
        press(0); press(1); press(2);
        idle(4);
        new_game = 1'b1;
        cycle();
        new_game = 1'b0;
        idle(3);

        // reset while a guess is pending
        press(0); press(1); press_n(0, 2); press(1); press_n(0, 3);
        idle(2);
        press(2);
        idle(4);
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        idle(3);

        // random traffic
        for (int c = 0; c < 4000; c++) begin
            rst         = ($urandom_range(0, 399) == 0);
            new_game    = ($urandom_range(0, 59) == 0);
            game_over   = ($urandom_range(0, 99) == 0);
            btn_inc     = ($urandom_range(0, 2) == 0);
            btn_next    = ($urandom_range(0, 3) == 0);
            btn_ok      = ($urandom_range(0, 5) == 0);
            guess_ready = ($urandom_range(0, 1) == 1);
            cycle();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
